// File: rtl/dma_rx_arb_pkg.sv
// Shared types, TUSER source-tag field placement and the round-robin search
// used by the DMA RX packet arbiter.
package dma_rx_arb_pkg;

  typedef enum logic {
    ARB = 1'b0,
    PKT = 1'b1
  } arb_state_t;

  localparam int MAX_QUEUES    = 8;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_SRC_W   = 8;

  // First requesting index after 'last', wrapping modulo num_queues.
  // Returns 'last' unchanged when nothing requests; callers qualify with |valid_vec.
  function automatic logic [2:0] next_rr(input logic [2:0]            last,
                                         input logic [MAX_QUEUES-1:0] valid_vec,
                                         input int                    num_queues = MAX_QUEUES);
    logic [2:0] idx;
    next_rr = last;
    for (int k = MAX_QUEUES; k >= 1; k--) begin
      if (k <= num_queues) begin
        idx = 3'((int'(last) + k) % num_queues);
        if (valid_vec[idx]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage registered AXI4-Stream slice (data/strb/user/last) with
// same-cycle load-and-drain for full throughput.
module axis_reg_slice #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     up_data,
  input  logic [DATA_W/8-1:0]   up_strb,
  input  logic [USER_W-1:0]     up_user,
  input  logic                  up_last,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [DATA_W-1:0]     dn_data,
  output logic [DATA_W/8-1:0]   dn_strb,
  output logic [USER_W-1:0]     dn_user,
  output logic                  dn_last,
  output logic                  dn_valid,
  input  logic                  dn_ready
);

  logic [DATA_W-1:0]   data_p1;
  logic [DATA_W/8-1:0] strb_p1;
  logic [USER_W-1:0]   user_p1;
  logic                last_p1;
  logic                vld_p1;

  assign up_ready = !vld_p1 || dn_ready;

  // Stage p1: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      strb_p1 <= '0;
      user_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (up_valid && up_ready) begin
      data_p1 <= up_data;
      strb_p1 <= up_strb;
      user_p1 <= up_user;
      last_p1 <= up_last;
      vld_p1  <= 1'b1;
    end else if (dn_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign dn_data  = data_p1;
  assign dn_strb  = strb_p1;
  assign dn_user  = user_p1;
  assign dn_last  = last_p1;
  assign dn_valid = vld_p1;

endmodule

// File: rtl/dma_rx_rr_arbiter.sv
// Packet-granular round-robin merge of C_NUM_QUEUES AXIS sources into the DMA ingress.
// Optional: DMA_RX_ARB_TUSER_SRC_EN tags TUSER[23:16] of each first beat with the one-hot source.
module dma_rx_rr_arbiter
  import dma_rx_arb_pkg::*;
#(
  parameter int C_NUM_QUEUES  = 4,
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [C_NUM_QUEUES*C_TUSER_WIDTH-1:0] S_AXIS_TUSER,
  input  logic [C_NUM_QUEUES-1:0]               S_AXIS_TVALID,
  output logic [C_NUM_QUEUES-1:0]               S_AXIS_TREADY,
  input  logic [C_NUM_QUEUES-1:0]               S_AXIS_TLAST,
  output logic [C_DATA_WIDTH-1:0]               M_AXIS_TDATA,
  output logic [C_DATA_WIDTH/8-1:0]             M_AXIS_TSTRB,
  output logic [C_TUSER_WIDTH-1:0]              M_AXIS_TUSER,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic                                  M_AXIS_TLAST,
  output logic [2:0]                            grant_idx
);

  localparam int STRB_W = C_DATA_WIDTH / 8;

  arb_state_t state, state_nxt;
  logic [2:0] grant, last_srv, rr_pick;
  logic [MAX_QUEUES-1:0] req_vec;
  logic req_any, slice_ready, accept, eop;
  logic [C_DATA_WIDTH-1:0]  sel_data;
  logic [STRB_W-1:0]        sel_strb;
  logic [C_TUSER_WIDTH-1:0] sel_user, beat_user;
  logic sel_valid, sel_last;

  assign req_vec = MAX_QUEUES'(S_AXIS_TVALID);
  assign req_any = |S_AXIS_TVALID;
  assign rr_pick = next_rr(last_srv, req_vec, C_NUM_QUEUES);

  always_comb begin
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < C_NUM_QUEUES; i++) begin
      if (grant == 3'(i)) begin
        sel_data  = S_AXIS_TDATA[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_strb  = S_AXIS_TSTRB[i*STRB_W +: STRB_W];
        sel_user  = S_AXIS_TUSER[i*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        sel_valid = S_AXIS_TVALID[i];
        sel_last  = S_AXIS_TLAST[i];
      end
    end
  end

  assign accept = (state == PKT) && sel_valid && slice_ready;
  assign eop    = accept && sel_last;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) state <= ARB;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB: if (req_any) state_nxt = PKT;
      PKT: if (eop)     state_nxt = ARB;
      default:          state_nxt = ARB;
    endcase
  end

  always_comb begin
    S_AXIS_TREADY = '0;
    for (int i = 0; i < C_NUM_QUEUES; i++) begin
      if ((state == PKT) && (grant == 3'(i))) S_AXIS_TREADY[i] = slice_ready;
    end
  end

  // Grant only moves in ARB, so a packet in flight cannot be pre-empted.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      grant    <= 3'd0;
      last_srv <= 3'(C_NUM_QUEUES - 1);
    end else begin
      if ((state == ARB) && req_any) grant <= rr_pick;
      if (eop) last_srv <= grant;
    end
  end

`ifdef DMA_RX_ARB_TUSER_SRC_EN
  logic first_beat;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN)       first_beat <= 1'b1;
    else if (state == ARB)   first_beat <= 1'b1;
    else if (accept)         first_beat <= 1'b0;
  end

  always_comb begin
    beat_user = sel_user;
    if (first_beat) beat_user[TUSER_SRC_LSB +: TUSER_SRC_W] = TUSER_SRC_W'(1) << grant;
  end
`else
  assign beat_user = sel_user;
`endif

  axis_reg_slice #(
    .DATA_W (C_DATA_WIDTH),
    .USER_W (C_TUSER_WIDTH)
  ) u_out_slice (
    .clk      (AXIS_ACLK),
    .rst_n    (AXIS_ARESETN),
    .up_data  (sel_data),
    .up_strb  (sel_strb),
    .up_user  (beat_user),
    .up_last  (sel_last),
    .up_valid ((state == PKT) && sel_valid),
    .up_ready (slice_ready),
    .dn_data  (M_AXIS_TDATA),
    .dn_strb  (M_AXIS_TSTRB),
    .dn_user  (M_AXIS_TUSER),
    .dn_last  (M_AXIS_TLAST),
    .dn_valid (M_AXIS_TVALID),
    .dn_ready (M_AXIS_TREADY)
  );

  assign grant_idx = grant;

endmodule
